dma_tcdm_burst_bridge: RTL

DMA_TCDM_BURST_BRIDGE -- requirements
Module: dma_tcdm_burst_bridge

---
 rtl/dma_tcdm_burst_bridge.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/dma_tcdm_burst_bridge.sv
// dma_tcdm_burst_bridge
//   Turns a single DMA burst command into a sequence of wide beats, each beat
//   split across NumBanks parallel TCDM bank ports. Write beats stream data
//   straight through to the banks; read beats are reassembled from per-bank
//   responses and queued in a small response FIFO. One burst is in flight.
//
// Ports
//   clk_i, rst_i                      clock, synchronous active-high reset
//   cmd_*                             burst command (addr, len = beats-1, write, id)
//   wdata_valid_i/wdata_ready_o,
//   wdata_i, wstrb_i                  write beat stream
//   rdata_valid_o/rdata_ready_i,
//   rdata_o, rdata_id_o, rdata_last_o read beat stream
//   wresp_valid_o/wresp_ready_i,
//   wresp_id_o                        write completion
//   mem_req_o/mem_gnt_i, mem_addr_o,
//   mem_wen_o (0 = write), mem_be_o,
//   mem_wdata_o                       per-bank request side (bank k = slice k)
//   mem_rvalid_i, mem_rdata_i         per-bank response, one cycle after grant
//   busy_o                            a command is accepted but not complete
//   dbg_state_o                       current FSM state (IDLE=0, ISSUE=1, DRAIN=2)
//
// Handshakes: every valid/ready pair transfers exactly in a cycle where both
// are high at the rising edge; a producer never withdraws valid or changes its
// payload before that transfer, and ready may depend combinationally on valid.
// The bank req/gnt pair is the exception: req stays up until gnt, gnt is
// honoured only for banks that are requesting.

module dma_tcdm_burst_bridge #(
  parameter int NumBanks      = 2,
  parameter int BankDataWidth = 32,
  parameter int AddrWidth     = 32,
  parameter int IdWidth       = 4,
  parameter int RespDepth     = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 cmd_valid_i,
  output logic                                 cmd_ready_o,
  input  logic [AddrWidth-1:0]                 cmd_addr_i,
  input  logic [7:0]                           cmd_len_i,
  input  logic                                 cmd_write_i,
  input  logic [IdWidth-1:0]                   cmd_id_i,
  input  logic                                 wdata_valid_i,
  output logic                                 wdata_ready_o,
  input  logic [NumBanks*BankDataWidth-1:0]    wdata_i,
  input  logic [NumBanks*BankDataWidth/8-1:0]  wstrb_i,
  output logic                                 rdata_valid_o,
  input  logic                                 rdata_ready_i,
  output logic [NumBanks*BankDataWidth-1:0]    rdata_o,
  output logic [IdWidth-1:0]                   rdata_id_o,
  output logic                                 rdata_last_o,
  output logic                                 wresp_valid_o,
  input  logic                                 wresp_ready_i,
  output logic [IdWidth-1:0]                   wresp_id_o,
  output logic [NumBanks-1:0]                  mem_req_o,
  input  logic [NumBanks-1:0]                  mem_gnt_i,
  output logic [NumBanks*AddrWidth-1:0]        mem_addr_o,
  output logic [NumBanks-1:0]                  mem_wen_o,
  output logic [NumBanks*BankDataWidth/8-1:0]  mem_be_o,
  output logic [NumBanks*BankDataWidth-1:0]    mem_wdata_o,
  input  logic [NumBanks-1:0]                  mem_rvalid_i,
  input  logic [NumBanks*BankDataWidth-1:0]    mem_rdata_i,
  output logic                                 busy_o,
  output logic [1:0]                           dbg_state_o
);

  localparam int BW        = NumBanks * BankDataWidth;
  localparam int BeatBytes = BW / 8;
  localparam int BankBytes = BankDataWidth / 8;
  localparam int PtrW      = (RespDepth > 1) ? $clog2(RespDepth) : 1;
  localparam int CntW      = $clog2(RespDepth + 1);

  localparam logic [AddrWidth-1:0] AlignMask = AddrWidth'(BeatBytes - 1);
  localparam logic [AddrWidth-1:0] BeatInc   = AddrWidth'(BeatBytes);
  localparam logic [CntW:0]        DepthLim  = (CntW + 1)'(RespDepth);
  localparam logic [PtrW-1:0]      PtrLast   = PtrW'(RespDepth - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Burst context
  logic [AddrWidth-1:0]     beat_addr_q;
  logic [7:0]               len_q;
  logic [7:0]               issue_cnt_q;  // beats retired on the request side
  logic [7:0]               rsp_cnt_q;    // read beats pushed into the FIFO
  logic                     write_q;
  logic [IdWidth-1:0]       id_q;
  logic [NumBanks-1:0]      gnt_mask_q;   // banks already granted this beat

  // Read response reassembly
  logic [NumBanks-1:0]      pend_rv_q;    // banks whose rvalid is due this cycle
  logic [NumBanks-1:0]      hold_vld_q;
  logic [BankDataWidth-1:0] hold_data_q [NumBanks];
  logic [CntW-1:0]          inflight_q;   // read beats retired, not yet pushed

  // Response FIFO
  logic [BW-1:0]            fifo_data_q [RespDepth];
  logic [RespDepth-1:0]     fifo_last_q;
  logic [PtrW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]          fifo_cnt_q;

  logic                     cmd_fire, can_issue, retire, last_retire;
  logic                     push, pop;
  logic [NumBanks-1:0]      gnt_eff, rv_eff, got;
  logic [BW-1:0]            push_data;
  logic [CntW:0]            occupancy;

  assign cmd_fire  = cmd_valid_i & cmd_ready_o;
  assign occupancy = {1'b0, fifo_cnt_q} + {1'b0, inflight_q};

  // Writes need the beat data present; reads need guaranteed FIFO room for
  // every beat that could still land, so the FIFO can never overflow.
  assign can_issue = write_q ? wdata_valid_i : (occupancy < DepthLim);

  assign mem_req_o   = (state_q == ISSUE && can_issue) ? ~gnt_mask_q : '0;
  assign gnt_eff     = mem_req_o & mem_gnt_i;
  assign retire      = (|gnt_eff) && (&(gnt_mask_q | gnt_eff));
  assign last_retire = retire && (issue_cnt_q == len_q);

  for (genvar k = 0; k < NumBanks; k++) begin : g_bank_addr
    assign mem_addr_o[k*AddrWidth +: AddrWidth] = beat_addr_q + AddrWidth'(k * BankBytes);
  end

  assign mem_wen_o     = {NumBanks{~write_q}};
  assign mem_be_o      = write_q ? wstrb_i : '1;
  assign mem_wdata_o   = wdata_i;
  assign wdata_ready_o = retire & write_q;

  // Only banks granted for a read last cycle may deliver data; anything else
  // (write beats, stale responses after reset) is dropped here.
  assign rv_eff = mem_rvalid_i & pend_rv_q;
  assign got    = hold_vld_q | rv_eff;
  assign push   = (|rv_eff) && (&got);

  always_comb begin
    push_data = '0;
    for (int k = 0; k < NumBanks; k++) begin
      push_data[k*BankDataWidth +: BankDataWidth] =
        rv_eff[k] ? mem_rdata_i[k*BankDataWidth +: BankDataWidth] : hold_data_q[k];
    end
  end

  assign rdata_valid_o = (fifo_cnt_q != '0);
  assign rdata_o       = fifo_data_q[rd_ptr_q];
  assign rdata_last_o  = fifo_last_q[rd_ptr_q];
  assign rdata_id_o    = id_q;
  assign pop           = rdata_valid_o & rdata_ready_i;

  assign wresp_valid_o = (state_q == DRAIN) & write_q;
  assign wresp_id_o    = id_q;
  assign cmd_ready_o   = (state_q == IDLE) & ~rst_i;
  assign busy_o        = (state_q != IDLE);
  assign dbg_state_o   = state_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (cmd_fire) state_d = ISSUE;
      ISSUE: if (last_retire) state_d = DRAIN;
      DRAIN: begin
        if (write_q) begin
          if (wresp_ready_i) state_d = IDLE;
        end else if (pop && rdata_last_o) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      beat_addr_q <= '0;
      len_q       <= '0;
      issue_cnt_q <= '0;
      rsp_cnt_q   <= '0;
      write_q     <= 1'b0;
      id_q        <= '0;
      gnt_mask_q  <= '0;
      pend_rv_q   <= '0;
      hold_vld_q  <= '0;
      inflight_q  <= '0;
      fifo_last_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
      for (int k = 0; k < NumBanks; k++) hold_data_q[k] <= '0;
      for (int i = 0; i < RespDepth; i++) fifo_data_q[i] <= '0;
    end else begin
      state_q <= state_d;

      if (cmd_fire) begin
        beat_addr_q <= cmd_addr_i & ~AlignMask;
        len_q       <= cmd_len_i;
        write_q     <= cmd_write_i;
        id_q        <= cmd_id_i;
        issue_cnt_q <= '0;
        rsp_cnt_q   <= '0;
        gnt_mask_q  <= '0;
      end else if (retire) begin
        gnt_mask_q  <= '0;
        beat_addr_q <= beat_addr_q + BeatInc;
        issue_cnt_q <= issue_cnt_q + 8'd1;
      end else begin
        gnt_mask_q  <= gnt_mask_q | gnt_eff;
      end

      pend_rv_q <= write_q ? '0 : gnt_eff;

      // Each bank's word is parked until the slowest bank of the beat returns.
      if (push) begin
        hold_vld_q <= '0;
      end else begin
        hold_vld_q <= got;
      end
      for (int k = 0; k < NumBanks; k++) begin
        if (rv_eff[k]) hold_data_q[k] <= mem_rdata_i[k*BankDataWidth +: BankDataWidth];
      end

      inflight_q <= inflight_q + CntW'(retire & ~write_q) - CntW'(push);

      if (push) begin
        fifo_data_q[wr_ptr_q] <= push_data;
        fifo_last_q[wr_ptr_q] <= (rsp_cnt_q == len_q);
        wr_ptr_q              <= (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PtrW'(1);
        rsp_cnt_q             <= rsp_cnt_q + 8'd1;
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PtrW'(1);
      end
      unique case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + CntW'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - CntW'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

endmodule
